// File: rtl/cl_div_seq.sv
// Sequential carry-less (GF(2)[x]) divider: long division MSB first, one or two dividend bits per cycle.
// Define CL_DIV_RADIX4_EN to retire two dividend bits per RUN cycle (same results, half the RUN time).
module cl_div_seq #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic [2*DATA_WIDTH-1:0]   dividend,
   input  logic [DATA_WIDTH:0]       divisor,
   output logic                      busy,
   output logic                      done,
   output logic [2*DATA_WIDTH-1:0]   quotient,
   output logic [DATA_WIDTH-1:0]     remainder,
   output logic                      div_zero
);

   localparam int W = DATA_WIDTH;
`ifdef CL_DIV_RADIX4_EN
   localparam int BPC = 2;
`else
   localparam int BPC = 1;
`endif
   localparam int STEPS = 2*W/BPC;
   localparam int CW    = $clog2(STEPS+1);
   localparam int DW    = $clog2(W+1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t          state, nxt;
   logic [2*W-1:0]  dvd_q;
   logic [W-1:0]    dvs_q;   // divisor bit W is implied by d and always cancels
   logic [DW-1:0]   d_q, deg;
   logic [CW-1:0]   cnt;
   logic [W:0]      s1;
`ifdef CL_DIV_RADIX4_EN
   logic [W:0]      s2;
`endif

   // One radix-2 step: returns {quotient bit, new remainder}
   function automatic logic [W:0] step(input logic [W-1:0] r, input logic b,
                                       input logic [W-1:0] dv, input logic [DW-1:0] d);
      logic [W:0] t;
      logic [W:0] res;
      t = {r, b};
      if (t[d]) res = {1'b1, t[W-1:0] ^ dv};
      else      res = {1'b0, t[W-1:0]};
      return res;
   endfunction

   always_comb begin
      deg = '0;
      for (int i = 0; i <= W; i++)
         if (divisor[i]) deg = DW'(i);
   end

   always_comb begin
      s1 = step(remainder, dvd_q[2*W-1], dvs_q, d_q);
`ifdef CL_DIV_RADIX4_EN
      s2 = step(s1[W-1:0], dvd_q[2*W-2], dvs_q, d_q);
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= nxt;
   end

   always_comb begin
      nxt = state;
      case (state)
         IDLE:    if (start) nxt = (divisor == '0) ? DONE : RUN;
         RUN:     if (cnt == CW'(STEPS-1)) nxt = DONE;
         DONE:    nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   always_comb begin
      busy = (state != IDLE);
      done = (state == DONE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dvd_q     <= '0;
         dvs_q     <= '0;
         d_q       <= '0;
         cnt       <= '0;
         quotient  <= '0;
         remainder <= '0;
         div_zero  <= 1'b0;
      end else begin
         case (state)
            IDLE: if (start) begin
               dvd_q     <= dividend;
               dvs_q     <= divisor[W-1:0];
               d_q       <= deg;
               cnt       <= '0;
               quotient  <= '0;
               remainder <= '0;
               div_zero  <= (divisor == '0);
            end
            RUN: begin
               cnt <= cnt + 1'b1;
`ifdef CL_DIV_RADIX4_EN
               quotient  <= {quotient[2*W-3:0], s1[W], s2[W]};
               remainder <= s2[W-1:0];
               dvd_q     <= {dvd_q[2*W-3:0], 2'b00};
`else
               quotient  <= {quotient[2*W-2:0], s1[W]};
               remainder <= s1[W-1:0];
               dvd_q     <= {dvd_q[2*W-2:0], 1'b0};
`endif
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_cl_div_seq.sv
// Bench for cl_div_seq at DATA_WIDTH=8: vector table, corner sequences and random ops, scoreboard-checked.
module tb_cl_div_seq;

   localparam int W = 8;
`ifdef CL_DIV_RADIX4_EN
   localparam int LAT = W + 1;
`else
   localparam int LAT = 2*W + 1;
`endif

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            start = 1'b0;
   logic [2*W-1:0]  dividend = '0;
   logic [W:0]      divisor = '0;
   logic            busy, done, div_zero;
   logic [2*W-1:0]  quotient;
   logic [W-1:0]    remainder;

   cl_div_seq #(.DATA_WIDTH(W)) dut (
      .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
      .busy(busy), .done(done), .quotient(quotient), .remainder(remainder), .div_zero(div_zero)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2*W-1:0] q;
      logic [W-1:0]   r;
      logic           dz;
   } res_t;

   typedef struct {
      logic [2*W-1:0] a;
      logic [W:0]     b;
      logic [2*W-1:0] q;
      logic [W-1:0]   r;
      logic           dz;
   } vec_t;

   res_t sb[$];
   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic int degree(input logic [W:0] b);
      int d = -1;
      for (int i = 0; i <= W; i++) if (b[i]) d = i;
      return d;
   endfunction

   // Textbook polynomial long division on the full-width dividend
   function automatic res_t ref_div(input logic [2*W-1:0] a, input logic [W:0] b);
      res_t o;
      logic [3*W:0] rem;
      int d;
      o.q = '0; o.r = '0; o.dz = 1'b0;
      d = degree(b);
      if (d < 0) begin
         o.dz = 1'b1;
         return o;
      end
      rem = {{(W+1){1'b0}}, a};
      for (int i = 2*W-1; i >= d; i--)
         if (rem[i]) begin
            rem = rem ^ ({{(2*W){1'b0}}, b} << (i-d));
            o.q[i-d] = 1'b1;
         end
      o.r = rem[W-1:0];
      return o;
   endfunction

   function automatic logic [3*W:0] clmul(input logic [2*W-1:0] q, input logic [W:0] b);
      logic [3*W:0] p = '0;
      for (int i = 0; i <= W; i++)
         if (b[i]) p = p ^ ({{(W+1){1'b0}}, q} << i);
      return p;
   endfunction

   task automatic wait_done(output int lat);
      lat = 1;
      while (!done && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic do_op(input logic [2*W-1:0] a, input logic [W:0] b);
      res_t e, g;
      int lat, d;
      e = ref_div(a, b);
      sb.push_back(e);
      dividend = a; divisor = b; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(lat);
      chk("latency", lat, e.dz ? 1 : LAT);
      if (done) begin
         g = sb.pop_front();
         chk("quotient", quotient, g.q);
         chk("remainder", remainder, g.r);
         chk("div_zero", div_zero, g.dz);
         chk("busy_in_done", busy, 1);
         if (!g.dz) begin
            d = degree(b);
            chk("clmul_identity", clmul(quotient, b) ^ remainder, a);
            chk("rem_degree", remainder >> d, 0);
         end
      end else begin
         void'(sb.pop_front());
      end
      @(posedge clk); #1;
      chk("done_pulse_end", done, 0);
      chk("busy_idle", busy, 0);
      chk("quotient_hold", quotient, e.q);
   endtask

   vec_t tbl[6];

   initial begin
      int lat, pulses;
      res_t e, g;
      tbl[0] = '{16'h0015, 9'h007, 16'h0007, 8'h00, 1'b0};
      tbl[1] = '{16'h0100, 9'h11B, 16'h0001, 8'h1B, 1'b0};
      tbl[2] = '{16'hABCD, 9'h001, 16'hABCD, 8'h00, 1'b0};
      tbl[3] = '{16'hABCD, 9'h000, 16'h0000, 8'h00, 1'b1};
      tbl[4] = '{16'hFFFF, 9'h100, 16'h00FF, 8'hFF, 1'b0};
      tbl[5] = '{16'h0000, 9'h11B, 16'h0000, 8'h00, 1'b0};

      #12;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_quotient", quotient, 0);
      chk("rst_remainder", remainder, 0);
      chk("rst_div_zero", div_zero, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      // Table vectors run back to back; the model must agree with the hand-derived results too
      foreach (tbl[i]) begin
         e = ref_div(tbl[i].a, tbl[i].b);
         chk("model_q", e.q, tbl[i].q);
         chk("model_r", e.r, tbl[i].r);
         do_op(tbl[i].a, tbl[i].b);
         chk("tbl_quotient", quotient, tbl[i].q);
         chk("tbl_remainder", remainder, tbl[i].r);
         chk("tbl_div_zero", div_zero, tbl[i].dz);
      end

      // Start pulsed mid-RUN with new operands must be ignored
      e = ref_div(16'h1234, 9'h11B);
      sb.push_back(e);
      dividend = 16'h1234; divisor = 9'h11B; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      dividend = 16'hFFFF; divisor = 9'h003; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      dividend = '0; divisor = '0;
      wait_done(lat);
      chk("midrun_latency", lat, LAT - 4);
      g = sb.pop_front();
      chk("midrun_quotient", quotient, g.q);
      chk("midrun_remainder", remainder, g.r);
      pulses = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (done) pulses++;
      end
      chk("midrun_extra_done", pulses, 0);

      // Reset five cycles into RUN: abandon without a done pulse
      dividend = 16'hFFFF; divisor = 9'h003; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (5) begin @(posedge clk); #1; end
      chk("pre_rst_busy", busy, 1);
      rst = 1'b1;
      #1;
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_done", done, 0);
      chk("mid_rst_quotient", quotient, 0);
      chk("mid_rst_remainder", remainder, 0);
      chk("mid_rst_div_zero", div_zero, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      pulses = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (done) pulses++;
      end
      chk("post_rst_no_done", pulses, 0);
      do_op(16'h0015, 9'h007);

      for (int n = 0; n < 1000; n++)
         do_op(16'($urandom), 9'($urandom_range(0, 511)));

      chk("scoreboard_empty", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
